// File: rtl/seg_pkg.sv
// seg_pkg: display codes, segment patterns and buffered display record for the scan driver.
package seg_pkg;
    localparam int NUM_DIGITS = 8;
    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_E     = 4'hB;
    localparam logic [3:0] CODE_N     = 4'hC;
    localparam logic [3:0] CODE_D     = 4'hD;
    localparam logic [3:0] CODE_R     = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;
    // Segment bit order is {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_E    = 7'b1001111;
    localparam logic [6:0] SEG_N    = 7'b0010101;
    localparam logic [6:0] SEG_D    = 7'b0111101;
    localparam logic [6:0] SEG_R    = 7'b0000101;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;
    localparam logic [15:0][6:0] SEG_TABLE = {SEG_OFF, SEG_R, SEG_D, SEG_N, SEG_E, SEG_DASH,
        SEG_9, SEG_8, SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   blank;
        logic [NUM_DIGITS-1:0]   blink;
    } disp_t;

    localparam disp_t DISP_RESET = '{digits: {NUM_DIGITS{CODE_BLANK}}, blank: '1, blink: '0};
endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: display data load bus feeding the scan driver.
interface seg_scan_driver_if;
    logic [31:0] digits;
    logic [7:0]  blank_mask;
    logic [7:0]  blink_mask;
    logic        load;
    modport master(output digits, blank_mask, blink_mask, load);
    modport slave(input digits, blank_mask, blink_mask, load);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: 4-bit display code to {a..g} segment pattern, forced dark when requested.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dark,
    output logic [6:0] seg
);
    assign seg = dark ? SEG_OFF : SEG_TABLE[code];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes eight buffered digits onto one 7-segment bus,
// swapping in new data only at frame boundaries and blinking selected digits.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 2
) (
    input  logic clk,
    input  logic rst,
    seg_scan_driver_if.slave bus,
    output logic a, b, c, d, e, f, g,
    output logic com1, com2, com3, com4, com5, com6, com7, com8,
    output logic frame_start
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [PW-1:0] pre_cnt;
    logic [2:0]    idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase, pend;
    disp_t         shadow, active, din;
    logic [6:0]    seg_next, seg_q;
    logic [7:0]    com_q;
    logic          term, frame_edge, dark;
    logic [3:0]    code;

    assign din        = '{digits: bus.digits, blank: bus.blank_mask, blink: bus.blink_mask};
    assign term       = pre_cnt == PW'(SCAN_DIV - 1);
    assign frame_edge = term && idx == 3'd7;
    assign code       = active.digits[{idx, 2'b00} +: 4];
    assign dark       = active.blank[idx] | (active.blink[idx] & blink_phase);

    seg7_decode u_dec (.code(code), .dark(dark), .seg(seg_next));

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt     <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            pend        <= 1'b0;
            shadow      <= DISP_RESET;
            active      <= DISP_RESET;
            seg_q       <= SEG_OFF;
            com_q       <= '1;
            frame_start <= 1'b0;
        end else begin
            pre_cnt     <= term ? '0 : pre_cnt + 1'b1;
            idx         <= term ? idx + 3'd1 : idx;
            seg_q       <= seg_next;
            com_q       <= ~(8'b1 << idx);
            frame_start <= frame_edge;
            if (bus.load)
                shadow <= din;
            // A load landing on the frame edge bypasses the shadow so no stale copy is swapped in
            if (frame_edge) begin
                pend <= 1'b0;
                if (bus.load)
                    active <= din;
                else if (pend)
                    active <= shadow;
                frame_cnt   <= (frame_cnt == FW'(BLINK_FRAMES - 1)) ? '0 : frame_cnt + 1'b1;
                blink_phase <= (frame_cnt == FW'(BLINK_FRAMES - 1)) ? ~blink_phase : blink_phase;
            end else if (bus.load) begin
                pend <= 1'b1;
            end
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;
    assign {com8, com7, com6, com5, com4, com3, com2, com1} = com_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard-checked bench for seg_scan_driver with targeted scenario checks.
module tb_seg_scan_driver;
    import seg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_driver_if bus();
    logic a, b, c, d, e, f, g;
    logic com1, com2, com3, com4, com5, com6, com7, com8, frame_start;

    seg_scan_driver #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .com1(com1), .com2(com2), .com3(com3), .com4(com4),
        .com5(com5), .com6(com6), .com7(com7), .com8(com8),
        .frame_start(frame_start)
    );

    logic [6:0]  seg;
    logic [7:0]  com;
    logic [15:0] obs;
    assign seg = {a, b, c, d, e, f, g};
    assign com = {com8, com7, com6, com5, com4, com3, com2, com1};
    assign obs = {seg, com, frame_start};

    int n_checks = 0;
    int n_fail = 0;
    int k = 0;
    logic [15:0] sb[$];

    function automatic logic [6:0] dec(input logic [3:0] cd);
        case (cd)
            4'h0: dec = 7'b1111110;
            4'h1: dec = 7'b0110000;
            4'h2: dec = 7'b1101101;
            4'h3: dec = 7'b1111001;
            4'h4: dec = 7'b0110011;
            4'h5: dec = 7'b1011011;
            4'h6: dec = 7'b1011111;
            4'h7: dec = 7'b1110000;
            4'h8: dec = 7'b1111111;
            4'h9: dec = 7'b1111011;
            4'hA: dec = 7'b0000001;
            4'hB: dec = 7'b1001111;
            4'hC: dec = 7'b0010101;
            4'hD: dec = 7'b0111101;
            4'hE: dec = 7'b0000101;
            default: dec = 7'b0000000;
        endcase
    endfunction

    // Reference model of the display pipeline; it predicts the pins of the following cycle
    int          m_pre, m_idx, m_fc;
    logic        m_bp, m_pend;
    logic [31:0] m_dg, m_sdg;
    logic [7:0]  m_bl, m_bk, m_sbl, m_sbk;
    logic [15:0] m_exp;
    logic        m_dark, m_edge;

    always_comb begin
        m_dark = m_bl[m_idx] | (m_bk[m_idx] & m_bp);
        m_edge = (m_pre == 3) && (m_idx == 7);
        m_exp  = {m_dark ? 7'h00 : dec(m_dg[4*m_idx +: 4]), ~(8'b1 << m_idx), m_edge};
    end

    always @(posedge clk) begin
        if (rst) begin
            m_pre <= 0; m_idx <= 0; m_fc <= 0; m_bp <= 1'b0; m_pend <= 1'b0;
            m_dg <= 32'hFFFF_FFFF; m_bl <= 8'hFF; m_bk <= 8'h00;
            m_sdg <= 32'hFFFF_FFFF; m_sbl <= 8'hFF; m_sbk <= 8'h00;
            sb.push_back({7'h00, 8'hFF, 1'b0});
        end else begin
            sb.push_back(m_exp);
            m_pre <= (m_pre == 3) ? 0 : m_pre + 1;
            if (m_pre == 3) m_idx <= (m_idx + 1) % 8;
            if (bus.load) begin
                m_sdg <= bus.digits; m_sbl <= bus.blank_mask; m_sbk <= bus.blink_mask;
            end
            if (m_edge) begin
                m_pend <= 1'b0;
                if (bus.load) begin
                    m_dg <= bus.digits; m_bl <= bus.blank_mask; m_bk <= bus.blink_mask;
                end else if (m_pend) begin
                    m_dg <= m_sdg; m_bl <= m_sbl; m_bk <= m_sbk;
                end
                if (m_fc == 1) begin
                    m_fc <= 0; m_bp <= ~m_bp;
                end else begin
                    m_fc <= m_fc + 1;
                end
            end else if (bus.load) begin
                m_pend <= 1'b1;
            end
        end
    end

    initial begin
        logic [15:0] ex;
        forever begin
            @(negedge clk);
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty k=%0d got %h", k, obs);
            end else begin
                ex = sb.pop_front();
                if (obs !== ex) begin
                    n_fail++;
                    $display("FAIL scoreboard k=%0d got %h want %h", k, obs, ex);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        k++;
    endtask

    task automatic do_load(input logic [31:0] dg, input logic [7:0] bl, input logic [7:0] bk);
        bus.digits = dg; bus.blank_mask = bl; bus.blink_mask = bk; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (obs !== {7'h00, 8'hFF, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_pins got %h want %h", obs, {7'h00, 8'hFF, 1'b0});
            end
        end
        rst = 1'b0;
        k = 0;
        tick();
        n_checks++;
        if (obs !== {7'h00, 8'hFE, 1'b0}) begin
            n_fail++;
            $display("FAIL first_cycle got %h want %h", obs, {7'h00, 8'hFE, 1'b0});
        end
        while (k < 4) tick();
        n_checks++;
        if (com !== 8'hFE) begin
            n_fail++;
            $display("FAIL com1_hold got %h want fe", com);
        end
        tick();
        n_checks++;
        if (com !== 8'hFD) begin
            n_fail++;
            $display("FAIL com2_fall got %h want fd", com);
        end
        while (k < 31) tick();
        n_checks++;
        if (frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL fs_early got %b want 0", frame_start);
        end
        tick();
        n_checks++;
        if (frame_start !== 1'b1 || com !== 8'h7F) begin
            n_fail++;
            $display("FAIL fs_pulse got fs=%b com=%h want fs=1 com=7f", frame_start, com);
        end
        tick();
        n_checks++;
        if (frame_start !== 1'b0 || com !== 8'hFE) begin
            n_fail++;
            $display("FAIL fs_end got fs=%b com=%h want fs=0 com=fe", frame_start, com);
        end
    endtask

    task automatic test_frame_load();
        logic [6:0] want [8];
        int base;
        want = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 7'h00, 7'h00, 7'h00, 7'h00};
        while (k % 32 != 12) tick();
        do_load(32'h5555_5555, 8'h00, 8'h00);
        do_load(32'hFFFF_1234, 8'hF0, 8'h00);
        while (k % 32 != 16) begin
            n_checks++;
            if (seg !== 7'h00 || com !== 8'hF7) begin
                n_fail++;
                $display("FAIL com4_dark k=%0d got seg=%h com=%h want seg=00 com=f7", k, seg, com);
            end
            tick();
        end
        base = (k / 32 + 1) * 32;
        for (int i = 0; i < 8; i++) begin
            while (k < base + 4 * i + 2) tick();
            n_checks++;
            if (seg !== want[i] || com !== ~(8'b1 << i)) begin
                n_fail++;
                $display("FAIL frame_load digit%0d got seg=%b com=%h want seg=%b com=%h",
                         i, seg, com, want[i], ~(8'b1 << i));
            end
        end
    endtask

    task automatic test_scan();
        int pulses = 0;
        logic [7:0] ec;
        for (int i = 0; i < 96; i++) begin
            tick();
            ec = ~(8'b1 << (((k - 1) % 32) / 4));
            pulses += int'(frame_start);
            n_checks++;
            if (com !== ec || frame_start !== (k % 32 == 0)) begin
                n_fail++;
                $display("FAIL scan k=%0d got com=%h fs=%b want com=%h fs=%b",
                         k, com, frame_start, ec, k % 32 == 0);
            end
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL scan_pulses got %0d want 3", pulses);
        end
    endtask

    task automatic test_blink();
        int base, fr;
        logic [6:0] w1;
        while (k % 32 != 20) tick();
        do_load(32'h0000_0080, 8'h00, 8'h02);
        base = (k / 32 + 1) * 32;
        for (int i = 0; i < 4; i++) begin
            while (k < base + 32 * i + 2) tick();
            n_checks++;
            if (seg !== 7'b1111110) begin
                n_fail++;
                $display("FAIL blink_digit0 frame%0d got %b want 1111110", i, seg);
            end
            while (k < base + 32 * i + 6) tick();
            fr = (k - 1) / 32;
            w1 = ((fr / 2) % 2 == 1) ? 7'h00 : 7'h7F;
            n_checks++;
            if (seg !== w1 || com !== 8'hFD) begin
                n_fail++;
                $display("FAIL blink_digit1 frame%0d got seg=%b com=%h want seg=%b com=fd",
                         fr, seg, com, w1);
            end
        end
    endtask

    task automatic test_edge_load();
        while (k % 32 != 10) tick();
        do_load(32'h0000_0005, 8'h00, 8'h00);
        while (k % 32 != 31) tick();
        do_load(32'h0000_000B, 8'hFE, 8'h00);
        for (int i = 0; i < 2; i++) begin
            while (k % 32 != 2) tick();
            n_checks++;
            if (seg !== 7'b1001111 || com !== 8'hFE) begin
                n_fail++;
                $display("FAIL edge_load pass%0d got seg=%b com=%h want seg=1001111 com=fe", i, seg, com);
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        while (k % 32 != 8) tick();
        do_load(32'h8888_8888, 8'h00, 8'h00);
        while (k % 32 != 22) tick();
        n_checks++;
        if (com !== 8'hDF) begin
            n_fail++;
            $display("FAIL pre_reset_com6 got %h want df", com);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (obs !== {7'h00, 8'hFF, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset got %h want %h", obs, {7'h00, 8'hFF, 1'b0});
        end
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            n_checks++;
            if (seg !== 7'h00 || com !== ~(8'b1 << (((k - 1) % 32) / 4))) begin
                n_fail++;
                $display("FAIL after_reset k=%0d got seg=%b com=%h want seg=0000000 com=%h",
                         k, seg, com, ~(8'b1 << (((k - 1) % 32) / 4)));
            end
        end
    endtask

    initial begin
        bus.digits = 32'hFFFF_FFFF;
        bus.blank_mask = 8'hFF;
        bus.blink_mask = 8'h00;
        bus.load = 1'b0;
        test_reset();
        test_frame_load();
        test_scan();
        test_blink();
        test_edge_load();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream display stage of the keypad/number-entry block.
- Takes eight 4-bit display codes plus per-digit blank and blink masks, and time-multiplexes them onto one shared 7-segment bus (a..g) and eight digit commons (com1..com8).
- New data is double-buffered and applied only at a frame boundary, so a frame never shows a mix of old and new digits.

Parameters:
- SCAN_DIV, 4: clock cycles each digit is driven (≥2); one frame = 8*SCAN_DIV cycles.
- BLINK_FRAMES, 2: complete frames per blink half-period (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- digits  in  32  display codes; digit i at [4i+3:4i]; digit 0 drives com1
- blank_mask  in  8  bit i=1 forces digit i dark
- blink_mask  in  8  bit i=1 makes digit i dark during blink phase 1
- load  in  1  capture digits/blank_mask/blink_mask into shadow registers
- a, b, c, d, e, f, g  out  1 each  segment drive, active-high
- com1 .. com8  out  1 each  digit common, active-low
- frame_start  out  1  one-cycle pulse when com1 begins a new frame

Behaviour:
- Reset is synchronous and active-high on rst at the rising edge of clk; one clock domain.
- Reset values:
  - pre_cnt=0, idx=0, frame_cnt=0, blink_phase=0, pend=0
  - shadow and active codes = 4'hF; blank masks = 8'hFF; blink masks = 0
  - outputs: a..g=0, com1..com8=1, frame_start=0
- Prescaler pre_cnt counts 0..SCAN_DIV-1 and wraps. At its terminal count, idx advances 0→7, then 7→0.
- Frame edge is the clock where pre_cnt is terminal and idx=7. On this edge:
  - if pend=1, shadow is copied to active and pend is cleared
  - frame_cnt increments; when it reaches BLINK_FRAMES it resets to 0 and blink_phase toggles
  - frame_start is registered high for the following cycle only
- load=1 on any edge: inputs are captured into shadow and pend is set.
- load coinciding with the frame edge: the new inputs go straight into active and pend stays 0; no stale swap.
- Repeated loads within a frame: the last one wins.
- Digit i is dark when blank_mask[i]=1, or when blink_mask[i]=1 and blink_phase=1.
- Decode table (bit order a..g):
  - 0-9: standard digit patterns
  - 4'hA: '-' (g only)
  - 4'hB: 'E' (a,d,e,f,g)
  - 4'hC: 'n' (c,e,g)
  - 4'hD: 'd' (b,c,d,e,g)
  - 4'hE: 'r' (e,g)
  - 4'hF: dark
- Outputs are registered with 1-cycle latency from state:
  - next-cycle pins = decode(active[idx]) and com(idx+1)=0, all others 1
  - exactly one com is low at any time outside reset
  - first cycle after rst deasserts: com1=0 with a dark digit
- Reset mid-frame: on the next edge all outputs return to reset values, the pending load is discarded, and scanning restarts at com1.
- Dead-time/ghosting blanking is not provided; the board handles it.

Decomposition:
- seg_pkg holds:
  - display code constants (CODE_DASH=4'hA … CODE_BLANK=4'hF)
  - the 7-bit segment pattern constants
  - the digit count (8)
- One combinational sub-module, seg7_decode (4-bit code + dark → 7 segment bits), instantiated once on the muxed digit.
- Scan/prescale/blink/buffer logic lives in seg_scan_driver.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2, frame = 32 cycles):
1. Reset and idle
   - Stimulus: rst=1 for 2 cycles, then 0.
   - Response: com1..com8=1 and a..g=0 during reset. Next cycle com1=0, a..g=0. com2 falls 4 cycles later. frame_start pulses at cycle 32 after release.
2. Frame-synchronous load
   - Stimulus: load with digits=32'hFFFF_1234 and blank_mask=8'hF0 while idx=3.
   - Response: com4 window stays dark. From the next com1, digit patterns are: com1 '4' (b,c,f,g), com2 '3' (a,b,c,d,g), com3 '2' (a,b,d,e,g), com4 '1' (b,c). com5..com8 stay dark.
3. Scan order and timing
   - Check over 3 frames.
   - Response: each com is low exactly 4 consecutive cycles, in order com1→com8→com1, never two low at once. frame_start is high exactly 1 cycle per 32.
4. Blink
   - Stimulus: digits=32'h0000_0080, blank_mask=0, blink_mask=8'h02.
   - Response: com2 shows '8' (all segments 1) in frames 0-1, dark in frames 2-3, then repeats. Digit 0 shows '0' (a..f) in every frame.
5. Load on the frame edge
   - Stimulus: load asserted on the idx=7 terminal cycle with digit0=4'hB.
   - Response: the very next com1 window shows 'E' (a,d,e,f,g).
6. Mid-frame reset
   - Stimulus: rst pulsed while com6 is low, with a load pending.
   - Response: next cycle all com=1 and a..g=0. After release, scanning restarts at com1 with all digits dark; the pending data never appears.
